cpu_bus_cycle_sequencer: RTL and testbench

//  Upstream stage of CHIPSET: converts single-transfer requests into 8088-style

---
 rtl/cpu_bus_cycle_sequencer_if.sv | 30 +++
 rtl/cpu_bus_cycle_sequencer.sv | 178 +++++++++++++++++
 tb/tb_cpu_bus_cycle_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_cycle_sequencer_if.sv
// Request/response handshake plus the CHIPSET-facing 8088 maximum-mode bus of cpu_bus_cycle_sequencer.
// master is the sequencer's view; slave is the requester/CHIPSET side.
interface cpu_bus_cycle_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_type;
    logic [19:0] req_address;
    logic [7:0]  req_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_error;
    logic [19:0] cpu_address;
    logic [7:0]  cpu_data_bus;
    logic [2:0]  processor_status;
    logic        processor_lock_n;
    logic        processor_ready;
    logic [7:0]  data_bus;

    modport master (
        input  req_valid, req_type, req_address, req_data, processor_ready, data_bus,
        output req_ready, rsp_valid, rsp_data, rsp_error,
               cpu_address, cpu_data_bus, processor_status, processor_lock_n
    );

    modport slave (
        output req_valid, req_type, req_address, req_data, processor_ready, data_bus,
        input  req_ready, rsp_valid, rsp_data, rsp_error,
               cpu_address, cpu_data_bus, processor_status, processor_lock_n
    );
endinterface

// File: rtl/cpu_bus_cycle_sequencer.sv
// Turns single-transfer requests into 8088 maximum-mode bus cycles (T1..T4, TW, INTA pairs with TI).
// Optional feature macro BUS_TIMEOUT_EN: aborts a cycle after TIMEOUT_CYCLES wait states.
module cpu_bus_cycle_sequencer
`ifdef BUS_TIMEOUT_EN
#(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
)
`endif
(
    input logic                       clock,
    input logic                       reset_n,
    cpu_bus_cycle_sequencer_if.master bus
);
    localparam logic [2:0] TYPE_INTA    = 3'b000;
    localparam logic [2:0] TYPE_IOR     = 3'b001;
    localparam logic [2:0] TYPE_IOW     = 3'b010;
    localparam logic [2:0] TYPE_HALT    = 3'b011;
    localparam logic [2:0] TYPE_CODE    = 3'b100;
    localparam logic [2:0] TYPE_MEMR    = 3'b101;
    localparam logic [2:0] TYPE_MEMW    = 3'b110;
    localparam logic [2:0] TYPE_PASSIVE = 3'b111;

    typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4, TI} state_t;

    state_t      state;
    logic [2:0]  cyc_type;
    logic [19:0] cyc_address;
    logic [7:0]  cyc_data;
    logic        inta_second;
    logic        ti_count;

    logic        is_read;
    logic        is_write;
    logic        inta_first;
    logic        leave_wait;

`ifdef BUS_TIMEOUT_EN
    logic [7:0]  wait_count;
    logic        timed_out;
`endif

    always_comb begin
        is_read    = (cyc_type == TYPE_IOR)  || (cyc_type == TYPE_CODE) ||
                     (cyc_type == TYPE_MEMR) || (cyc_type == TYPE_INTA);
        is_write   = (cyc_type == TYPE_IOW)  || (cyc_type == TYPE_MEMW);
        inta_first = (cyc_type == TYPE_INTA) && !inta_second;
        // HALT never waits on processor_ready.
        leave_wait = ((state == T3) && ((cyc_type == TYPE_HALT) || bus.processor_ready)) ||
                     ((state == TW) && bus.processor_ready);
    end

`ifdef BUS_TIMEOUT_EN
    always_comb begin
        timed_out = (state == TW) && !bus.processor_ready && (wait_count >= TIMEOUT_CYCLES);
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state                <= IDLE;
            cyc_type             <= TYPE_PASSIVE;
            cyc_address          <= '0;
            cyc_data             <= '0;
            inta_second          <= 1'b0;
            ti_count             <= 1'b0;
            bus.req_ready        <= 1'b0;
            bus.rsp_valid        <= 1'b0;
            bus.rsp_data         <= 8'h00;
            bus.rsp_error        <= 1'b0;
            bus.cpu_address      <= '0;
            bus.cpu_data_bus     <= 8'h00;
            bus.processor_status <= TYPE_PASSIVE;
            bus.processor_lock_n <= 1'b1;
`ifdef BUS_TIMEOUT_EN
            wait_count           <= 8'd0;
`endif
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_error <= 1'b0;
            unique case (state)
                IDLE: begin
                    bus.req_ready        <= 1'b1;
                    bus.cpu_address      <= '0;
                    bus.cpu_data_bus     <= 8'h00;
                    bus.processor_status <= TYPE_PASSIVE;
                    bus.processor_lock_n <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        cyc_type      <= bus.req_type;
                        cyc_address   <= bus.req_address;
                        cyc_data      <= bus.req_data;
                        inta_second   <= 1'b0;
                        // Undefined type 111 is answered at once without touching the bus.
                        if (bus.req_type == TYPE_PASSIVE) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_data  <= 8'h00;
                        end else begin
                            state                <= T1;
                            bus.cpu_address      <= bus.req_address;
                            bus.processor_status <= bus.req_type;
                        end
                    end
                end
                T1: begin
                    state <= T2;
                    if (is_write) begin
                        bus.cpu_data_bus <= cyc_data;
                    end
                    if (inta_first) begin
                        bus.processor_lock_n <= 1'b0;
                    end
                end
                T2: begin
                    state <= T3;
`ifdef BUS_TIMEOUT_EN
                    wait_count <= 8'd0;
`endif
                end
                T3, TW: begin
                    if (leave_wait) begin
                        state                <= T4;
                        bus.processor_status <= TYPE_PASSIVE;
                        if (!inta_first) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_data  <= is_read ? bus.data_bus : 8'h00;
                        end
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (timed_out) begin
                        // Setting inta_second makes T4 return to IDLE, skipping INTA cycle 2.
                        state                <= T4;
                        bus.processor_status <= TYPE_PASSIVE;
                        bus.processor_lock_n <= 1'b1;
                        bus.rsp_valid        <= 1'b1;
                        bus.rsp_error        <= 1'b1;
                        bus.rsp_data         <= 8'hFF;
                        inta_second          <= 1'b1;
                    end else begin
                        state      <= TW;
                        wait_count <= wait_count + 8'd1;
                    end
`else
                    else begin
                        state <= TW;
                    end
`endif
                end
                T4: begin
                    if (inta_first) begin
                        state    <= TI;
                        ti_count <= 1'b0;
                    end else begin
                        state                <= IDLE;
                        bus.req_ready        <= 1'b1;
                        bus.cpu_address      <= '0;
                        bus.cpu_data_bus     <= 8'h00;
                        bus.processor_lock_n <= 1'b1;
                    end
                end
                TI: begin
                    if (!ti_count) begin
                        ti_count <= 1'b1;
                    end else begin
                        state                <= T1;
                        ti_count             <= 1'b0;
                        inta_second          <= 1'b1;
                        bus.processor_lock_n <= 1'b1;
                        bus.cpu_address      <= cyc_address;
                        bus.processor_status <= cyc_type;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_bus_cycle_sequencer.sv
// Bench for cpu_bus_cycle_sequencer: a per-cycle schedule of stimulus and expected outputs is
// generated from the bus-cycle rules, then replayed against the DUT with one compare per clock.
module tb_cpu_bus_cycle_sequencer;
    localparam logic [2:0] INTA = 3'b000;
    localparam logic [2:0] IOR  = 3'b001;
    localparam logic [2:0] IOW  = 3'b010;
    localparam logic [2:0] HALT = 3'b011;
    localparam logic [2:0] CODE = 3'b100;
    localparam logic [2:0] MEMR = 3'b101;
    localparam logic [2:0] MEMW = 3'b110;
    localparam logic [2:0] UNDEF = 3'b111;

    logic clock = 1'b0;
    logic reset_n;
    cpu_bus_cycle_sequencer_if bus();

`ifdef BUS_TIMEOUT_EN
    localparam bit HAS_TIMEOUT = 1'b1;
    localparam int TIMEOUT     = 4;
    cpu_bus_cycle_sequencer #(.TIMEOUT_CYCLES(8'd4)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
`else
    localparam bit HAS_TIMEOUT = 1'b0;
    localparam int TIMEOUT     = 0;
    cpu_bus_cycle_sequencer dut (.clock(clock), .reset_n(reset_n), .bus(bus));
`endif

    always #5 clock = ~clock;

    typedef struct packed {
        logic        reset_n;
        logic        req_valid;
        logic [2:0]  req_type;
        logic [19:0] req_address;
        logic [7:0]  req_data;
        logic        processor_ready;
        logic [7:0]  data_bus;
    } stim_t;

    typedef struct packed {
        logic        req_ready;
        logic        rsp_valid;
        logic [7:0]  rsp_data;
        logic        rsp_error;
        logic [19:0] cpu_address;
        logic [7:0]  cpu_data_bus;
        logic [2:0]  processor_status;
        logic        processor_lock_n;
    } obs_t;

    stim_t      stim_q[$];
    obs_t       exp_q[$];
    logic [7:0] held_rsp;
    int         n_checks;
    int         n_fail;

    function automatic stim_t busy_stim(logic ready, logic [7:0] dbus);
        stim_t s;
        s.reset_n         = 1'b1;
        s.req_valid       = 1'($urandom);
        s.req_type        = 3'($urandom);
        s.req_address     = 20'($urandom);
        s.req_data        = 8'($urandom);
        s.processor_ready = ready;
        s.data_bus        = dbus;
        return s;
    endfunction

    function automatic obs_t idle_obs(logic rdy);
        obs_t o;
        o.req_ready        = rdy;
        o.rsp_valid        = 1'b0;
        o.rsp_data         = held_rsp;
        o.rsp_error        = 1'b0;
        o.cpu_address      = 20'h00000;
        o.cpu_data_bus     = 8'h00;
        o.processor_status = 3'b111;
        o.processor_lock_n = 1'b1;
        return o;
    endfunction

    function automatic int rsp_index(int from);
        for (int i = from; i < exp_q.size(); i++) begin
            if (exp_q[i].rsp_valid) return i;
        end
        return -1;
    endfunction

    task automatic push(input stim_t s, input obs_t o);
        stim_q.push_back(s);
        exp_q.push_back(o);
    endtask

    task automatic gen_reset(input int cycles);
        stim_t s;
        for (int i = 0; i < cycles; i++) begin
            s = busy_stim(1'b0, 8'($urandom));
            s.reset_n = 1'b0;
            held_rsp = 8'h00;
            push(s, idle_obs(1'b0));
        end
        push(busy_stim(1'($urandom), 8'($urandom)), idle_obs(1'b1));
    endtask

    task automatic gen_gap(input int cycles);
        stim_t s;
        for (int i = 0; i < cycles; i++) begin
            s = busy_stim(1'($urandom), 8'($urandom));
            s.req_valid = 1'b0;
            push(s, idle_obs(1'b1));
        end
    endtask

    // One T1..T4 bus cycle; 'entry' is the stimulus whose clock edge starts T1.
    task automatic gen_cycle(input stim_t entry, input logic [2:0] t, input logic [19:0] a,
                             input logic [7:0] d, input bit first_inta, input int waits,
                             input logic [7:0] rbyte, output bit aborted);
        obs_t  o;
        stim_t s;
        bit    wr;
        bit    rd;
        int    n;
        wr = (t == IOW) || (t == MEMW);
        rd = (t == IOR) || (t == CODE) || (t == MEMR) || (t == INTA);
        aborted = 1'b0;
        o = idle_obs(1'b0);
        o.cpu_address      = a;
        o.processor_status = t;
        push(entry, o);
        if (wr) o.cpu_data_bus = d;
        if (first_inta) o.processor_lock_n = 1'b0;
        push(busy_stim(1'($urandom), 8'($urandom)), o);
        push(busy_stim(1'($urandom), 8'($urandom)), o);
        if (t == HALT) begin
            s = busy_stim(1'b0, 8'($urandom));
        end else begin
            n = waits;
            if (HAS_TIMEOUT && waits > TIMEOUT) begin
                n = TIMEOUT;
                aborted = 1'b1;
            end
            for (int j = 0; j < n; j++) push(busy_stim(1'b0, 8'($urandom)), o);
            s = busy_stim(!aborted, rbyte);
        end
        o.processor_status = 3'b111;
        if (aborted) begin
            o.rsp_valid        = 1'b1;
            o.rsp_error        = 1'b1;
            o.rsp_data         = 8'hFF;
            o.processor_lock_n = 1'b1;
        end else if (!first_inta) begin
            o.rsp_valid = 1'b1;
            o.rsp_data  = rd ? rbyte : 8'h00;
        end
        if (o.rsp_valid) held_rsp = o.rsp_data;
        push(s, o);
    endtask

    task automatic gen_txn(input logic [2:0] t, input logic [19:0] a, input logic [7:0] d,
                           input int w1, input int w2, input logic [7:0] rb1, input logic [7:0] rb2);
        stim_t s;
        obs_t  o;
        bit    ab;
        s = busy_stim(1'($urandom), 8'($urandom));
        s.req_valid   = 1'b1;
        s.req_type    = t;
        s.req_address = a;
        s.req_data    = d;
        if (t == UNDEF) begin
            held_rsp = 8'h00;
            o = idle_obs(1'b0);
            o.rsp_valid = 1'b1;
            push(s, o);
        end else begin
            gen_cycle(s, t, a, d, t == INTA, w1, rb1, ab);
            if (t == INTA && !ab) begin
                o = idle_obs(1'b0);
                o.cpu_address      = a;
                o.processor_lock_n = 1'b0;
                push(busy_stim(1'($urandom), 8'($urandom)), o);
                push(busy_stim(1'($urandom), 8'($urandom)), o);
                gen_cycle(busy_stim(1'($urandom), 8'($urandom)), t, a, d, 1'b0, w2, rb2, ab);
            end
        end
        push(busy_stim(1'($urandom), 8'($urandom)), idle_obs(1'b1));
    endtask

    // IOR stalled in its first TW, then reset_n drops together with ready low.
    task automatic gen_reset_in_wait(input logic [19:0] a);
        stim_t s;
        obs_t  o;
        s = busy_stim(1'b0, 8'($urandom));
        s.req_valid   = 1'b1;
        s.req_type    = IOR;
        s.req_address = a;
        o = idle_obs(1'b0);
        o.cpu_address      = a;
        o.processor_status = IOR;
        push(s, o);
        push(busy_stim(1'($urandom), 8'($urandom)), o);
        push(busy_stim(1'($urandom), 8'($urandom)), o);
        push(busy_stim(1'b0, 8'($urandom)), o);
        gen_reset(1);
    endtask

    task automatic check_model(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("[TB] FAIL %s: model gives %0d, required %0d", name, got, want);
        end
    endtask

    task automatic build_schedule();
        int i0;
        int idx;
        gen_reset(2);
        gen_gap(1);

        i0 = exp_q.size();
        gen_txn(MEMW, 20'hB8000, 8'h01, 0, 0, 8'h5A, 8'h00);
        check_model("memw_rsp_clock", rsp_index(i0) - i0 + 1, 4);

        gen_txn(IOW, 20'h00063, 8'h99, 0, 0, 8'h11, 8'h00);
        i0 = exp_q.size();
        gen_txn(IOR, 20'h00062, 8'h00, 1, 0, 8'hCC, 8'h00);
        idx = rsp_index(i0);
        check_model("ior_rsp_data", (idx < 0) ? -1 : int'(exp_q[idx].rsp_data), 'hCC);

        i0 = exp_q.size();
        gen_txn(MEMR, 20'h12345, 8'h00, 3, 0, 8'hA7, 8'h00);
        check_model("memr_3tw_rsp_clock", rsp_index(i0) - i0 + 1, 7);

        i0 = exp_q.size();
        gen_txn(INTA, 20'h00000, 8'h00, 0, 0, 8'h3C, 8'h62);
        idx = rsp_index(i0);
        check_model("inta_rsp_clock", idx - i0 + 1, 10);
        check_model("inta_rsp_data", (idx < 0) ? -1 : int'(exp_q[idx].rsp_data), 'h62);

        gen_txn(HALT, 20'h00000, 8'h00, 2, 0, 8'hEE, 8'h00);
        gen_txn(UNDEF, 20'hFFFFF, 8'h77, 0, 0, 8'h00, 8'h00);
        gen_txn(INTA, 20'h00020, 8'h00, 2, 1, 8'h00, 8'h09);
        gen_reset_in_wait(20'h00062);
        gen_gap(1);

        if (HAS_TIMEOUT) begin
            i0 = exp_q.size();
            gen_txn(MEMR, 20'h00400, 8'h00, 10, 0, 8'h00, 8'h00);
            idx = rsp_index(i0);
            check_model("timeout_rsp_clock", idx - i0 + 1, 8);
            check_model("timeout_rsp_error", (idx < 0) ? -1 : int'(exp_q[idx].rsp_error), 1);
            gen_txn(INTA, 20'h00000, 8'h00, 9, 0, 8'h00, 8'h00);
        end

        for (int n = 0; n < 80; n++) begin
            gen_gap($urandom_range(0, 2));
            if ($urandom_range(0, 14) == 0) begin
                gen_reset_in_wait(20'($urandom));
            end else if ($urandom_range(0, 19) == 0) begin
                gen_reset($urandom_range(1, 2));
            end else begin
                gen_txn(3'($urandom), 20'($urandom), 8'($urandom),
                        $urandom_range(0, HAS_TIMEOUT ? 6 : 4), $urandom_range(0, HAS_TIMEOUT ? 6 : 4),
                        8'($urandom), 8'($urandom));
            end
        end
    endtask

    task automatic apply_stimulus(input stim_t s);
        reset_n             = s.reset_n;
        bus.req_valid       = s.req_valid;
        bus.req_type        = s.req_type;
        bus.req_address     = s.req_address;
        bus.req_data        = s.req_data;
        bus.processor_ready = s.processor_ready;
        bus.data_bus        = s.data_bus;
    endtask

    task automatic check_output(input int k, input obs_t e);
        obs_t a;
        a.req_ready        = bus.req_ready;
        a.rsp_valid        = bus.rsp_valid;
        a.rsp_data         = bus.rsp_data;
        a.rsp_error        = bus.rsp_error;
        a.cpu_address      = bus.cpu_address;
        a.cpu_data_bus     = bus.cpu_data_bus;
        a.processor_status = bus.processor_status;
        a.processor_lock_n = bus.processor_lock_n;
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("[TB] FAIL cycle %0d bus_outputs: got rdy=%b rv=%b rd=%h err=%b addr=%h db=%h st=%b lock=%b; required rdy=%b rv=%b rd=%h err=%b addr=%h db=%h st=%b lock=%b",
                     k, a.req_ready, a.rsp_valid, a.rsp_data, a.rsp_error, a.cpu_address,
                     a.cpu_data_bus, a.processor_status, a.processor_lock_n,
                     e.req_ready, e.rsp_valid, e.rsp_data, e.rsp_error, e.cpu_address,
                     e.cpu_data_bus, e.processor_status, e.processor_lock_n);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        held_rsp = 8'h00;
        build_schedule();
        apply_stimulus(stim_q[0]);
        for (int k = 0; k < stim_q.size(); k++) begin
            @(posedge clock);
            #1;
            check_output(k, exp_q[k]);
            if (k + 1 < stim_q.size()) apply_stimulus(stim_q[k + 1]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
